// File: rtl/mouse_event_fifo_port.sv
// Mouse sample FIFO with an 8-register bus window and a maskable threshold interrupt.
// The FIFO head fields are readable on the bus. A write to STATUS pops the head.
module mouse_event_fifo_port #(
  parameter logic [7:0]  BASE_ADDR  = 8'hA0,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter logic [7:0]  IRQ_THRESH = 8'd1
) (
  input  logic              CLK_100,
  input  logic              RESET,
  input  logic              SAMPLE_VALID,
  input  logic [3:0]        SAMPLE_STATUS,
  input  logic [7:0]        SAMPLE_X,
  input  logic [7:0]        SAMPLE_Y,
  input  logic [7:0]        SAMPLE_DX,
  input  logic [7:0]        SAMPLE_DY,
  inout  wire  [7:0]        BUS_DATA,
  input  logic [7:0]        BUS_ADDR,
  input  logic              BUS_WE,
  output logic              BUS_INTERRUPT_RAISE,
  input  logic              BUS_INTERRUPT_ACK,
  output logic [ADDR_W:0]   FIFO_COUNT,
  output logic              OVERFLOW
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [ADDR_W:0] FullCount = DEPTH[ADDR_W:0];

  typedef struct packed {
    logic [3:0] status;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] dx;
    logic [7:0] dy;
  } sample_t;

  sample_t         mem_q [DEPTH];
  sample_t         mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            irq_q, irq_d;
  logic            irq_en_q, irq_en_d;
  logic [7:0]      thresh_q, thresh_d;
  logic            rd_en_q, rd_en_d;
  logic [7:0]      rd_data_q, rd_data_d;

  logic [7:0] offset_full;
  logic [2:0] offset;
  logic       in_win, rd_req, wr_req;
  logic       empty, full, pop_ok, push_ok, ovf_set, irq_set;
  logic [7:0] wdata, thresh_eff;
  sample_t    head, in_sample;

  // Modular subtraction gives a single unsigned compare for the window test.
  assign offset_full = BUS_ADDR - BASE_ADDR;
  assign in_win      = offset_full < 8'd8;
  assign offset      = offset_full[2:0];
  assign rd_req      = in_win & ~BUS_WE;
  assign wr_req      = in_win & BUS_WE;
  assign wdata       = BUS_DATA;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FullCount);
  assign pop_ok     = wr_req && (offset == 3'd0) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push_ok    = SAMPLE_VALID && (!full || pop_ok);
  assign ovf_set    = SAMPLE_VALID && full && !pop_ok;
  assign head       = empty ? '0 : mem_q[rd_ptr_q];
  assign in_sample  = {SAMPLE_STATUS, SAMPLE_X, SAMPLE_Y, SAMPLE_DX, SAMPLE_DY};
  assign thresh_eff = (thresh_q == 8'd0) ? 8'd1 : thresh_q;

  assign BUS_DATA            = rd_en_q ? rd_data_q : 8'hZZ;
  assign BUS_INTERRUPT_RAISE = irq_q;
  assign FIFO_COUNT          = count_q;
  assign OVERFLOW            = overflow_q;

  // FIFO storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = in_sample;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Control registers, sticky overflow and interrupt request
  always_comb begin
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;
    thresh_d   = thresh_q;
    irq_d      = irq_q;
    irq_set    = 1'b0;
    if (wr_req && (offset == 3'd6)) begin
      irq_en_d = wdata[0];
      if (wdata[1]) begin
        overflow_d = 1'b0;
      end
    end
    if (wr_req && (offset == 3'd7)) begin
      thresh_d = wdata;
    end
    // A fresh overflow beats a same-cycle clear.
    if (ovf_set) begin
      overflow_d = 1'b1;
    end
    irq_set = push_ok && irq_en_q && (8'(count_d) >= thresh_eff);
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (BUS_INTERRUPT_ACK) begin
      irq_d = 1'b0;
    end
  end

  // Registered read mux; the bus is driven one cycle after the read address
  always_comb begin
    rd_en_d   = rd_req;
    rd_data_d = 8'h00;
    case (offset)
      3'd0:    rd_data_d = {overflow_q, full, empty, 1'b0, head.status};
      3'd1:    rd_data_d = head.x;
      3'd2:    rd_data_d = head.y;
      3'd3:    rd_data_d = head.dx;
      3'd4:    rd_data_d = head.dy;
      3'd5:    rd_data_d = 8'(count_q);
      3'd6:    rd_data_d = {7'b0, irq_en_q};
      default: rd_data_d = thresh_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK_100) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      irq_en_q   <= 1'b1;
      thresh_q   <= IRQ_THRESH;
      rd_en_q    <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
      irq_en_q   <= irq_en_d;
      thresh_q   <= thresh_d;
      rd_en_q    <= rd_en_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Sample storage needs no reset; occupancy tracking gates its visibility
  always_ff @(posedge CLK_100) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_mouse_event_fifo_port.sv
// Bench for mouse_event_fifo_port: directed vector table, hand sequences and a
// randomized run checked against a queue-based reference model.
module tb_mouse_event_fifo_port;

  localparam logic [7:0] BASE = 8'hA0;
  localparam int DEPTH = 8;
  localparam int BASE_I = 160;

  typedef struct packed {
    logic [3:0] st;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] dx;
    logic [7:0] dy;
  } smp_t;

  typedef struct {
    bit          valid;
    bit          we;
    bit          ack;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [35:0] smp;
    logic [7:0]  exp_bus;
    bit          exp_irq;
    int          exp_cnt;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic [3:0] smp_status;
  logic [7:0] smp_x, smp_y, smp_dx, smp_dy;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic       ack;
  logic       irq;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       tb_drv_en;
  logic [7:0] tb_drv_data;
  tri1  [7:0] bus_data;

  // Undriven bus reads back as 8'hFF through the pull-up.
  assign bus_data = tb_drv_en ? tb_drv_data : 8'hzz;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] last_bus;

  // Reference model state
  smp_t       mq[$];
  bit         m_ovf, m_irq, m_ien, m_rd_en;
  logic [7:0] m_thr, m_rd_data;

  mouse_event_fifo_port dut (
    .CLK_100             (clk),
    .RESET               (rst),
    .SAMPLE_VALID        (sample_valid),
    .SAMPLE_STATUS       (smp_status),
    .SAMPLE_X            (smp_x),
    .SAMPLE_Y            (smp_y),
    .SAMPLE_DX           (smp_dx),
    .SAMPLE_DY           (smp_dy),
    .BUS_DATA            (bus_data),
    .BUS_ADDR            (bus_addr),
    .BUS_WE              (bus_we),
    .BUS_INTERRUPT_RAISE (irq),
    .BUS_INTERRUPT_ACK   (ack),
    .FIFO_COUNT          (fifo_count),
    .OVERFLOW            (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] off);
    smp_t h;
    int   n;
    n = mq.size();
    h = (n > 0) ? mq[0] : '0;
    case (off)
      3'd0:    return {m_ovf, n == DEPTH, n == 0, 1'b0, h.st};
      3'd1:    return h.x;
      3'd2:    return h.y;
      3'd3:    return h.dx;
      3'd4:    return h.dy;
      3'd5:    return 8'(n);
      3'd6:    return {7'b0, m_ien};
      default: return m_thr;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    int   a, off, thr;
    bit   in_win, wr, pop, push, ovf_new;
    smp_t s;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_irq = 0; m_ien = 1; m_thr = 8'd1; m_rd_en = 0; m_rd_data = 8'h00;
      return;
    end
    a       = int'(bus_addr);
    in_win  = (a >= BASE_I) && (a <= BASE_I + 7);
    off     = a - BASE_I;
    m_rd_en = in_win && !bus_we;
    if (m_rd_en) m_rd_data = m_read(off[2:0]);
    wr      = in_win && bus_we;
    pop     = wr && (off == 0) && (mq.size() > 0);
    push    = sample_valid;
    ovf_new = 0;
    if (sample_valid && mq.size() == DEPTH && !pop) begin
      push = 0;
      ovf_new = 1;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      s = {smp_status, smp_x, smp_y, smp_dx, smp_dy};
      mq.push_back(s);
    end
    thr = (m_thr == 0) ? 1 : int'(m_thr);
    if (push && m_ien && mq.size() >= thr) m_irq = 1;
    else if (ack) m_irq = 0;
    if (wr && off == 6 && tb_drv_data[1]) m_ovf = 0;
    if (ovf_new) m_ovf = 1;
    if (wr && off == 6) m_ien = tb_drv_data[0];
    if (wr && off == 7) m_thr = tb_drv_data;
  endtask

  // One clock: apply inputs, return them to idle, compare DUT with the model.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    sample_valid = 0; bus_we = 0; tb_drv_en = 0; bus_addr = 8'h00; ack = 0; rst = 0;
    #1;
    last_bus = bus_data;
    chk("model count", 32'(fifo_count), 32'(mq.size()));
    chk("model overflow", 32'(overflow), 32'(m_ovf));
    chk("model irq", 32'(irq), 32'(m_irq));
    chk("model bus", 32'(bus_data), m_rd_en ? 32'(m_rd_data) : 32'hFF);
  endtask

  task automatic set_sample(input logic [3:0] st, input logic [7:0] x);
    smp_status = st; smp_x = x; smp_y = x ^ 8'h5A; smp_dx = x + 8'd1; smp_dy = x + 8'd2;
    sample_valid = 1;
  endtask

  task automatic push(input logic [3:0] st, input logic [7:0] x);
    set_sample(st, x);
    step();
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    bus_addr = BASE + 8'(off); bus_we = 1; tb_drv_en = 1; tb_drv_data = d;
    step();
  endtask

  // Read, then an idle cycle so a following write never fights the DUT driver.
  task automatic rd(input logic [2:0] off, output logic [7:0] val);
    bus_addr = BASE + 8'(off); bus_we = 0;
    step();
    val = last_bus;
    step();
  endtask

  vec_t vecs[$];
  logic [7:0] v8;

  initial begin
    rst = 1; sample_valid = 0; smp_status = 0; smp_x = 0; smp_y = 0; smp_dx = 0; smp_dy = 0;
    bus_addr = 8'h00; bus_we = 0; ack = 0; tb_drv_en = 0; tb_drv_data = 0;
    step();
    rst = 1;
    step();

    // Reset register values, single push/read/ack/pop.
    for (int i = 0; i < 8; i++) begin
      v8 = (i == 0) ? 8'h20 : (i >= 6) ? 8'h01 : 8'h00;
      vecs.push_back('{0, 0, 0, BASE + 8'(i), 8'h00, 36'h0, v8, 0, 0});
    end
    vecs.push_back('{0, 0, 0, 8'h00, 8'h00, 36'h0, 8'hFF, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, {4'h9, 8'h10, 8'h20, 8'h03, 8'h04}, 8'hFF, 1, 1});
    vecs.push_back('{0, 0, 0, BASE + 8'd0, 8'h00, 36'h0, 8'h09, 1, 1});
    vecs.push_back('{0, 0, 0, BASE + 8'd1, 8'h00, 36'h0, 8'h10, 1, 1});
    vecs.push_back('{0, 0, 0, BASE + 8'd2, 8'h00, 36'h0, 8'h20, 1, 1});
    vecs.push_back('{0, 0, 0, BASE + 8'd3, 8'h00, 36'h0, 8'h03, 1, 1});
    vecs.push_back('{0, 0, 0, BASE + 8'd4, 8'h00, 36'h0, 8'h04, 1, 1});
    vecs.push_back('{0, 0, 0, BASE + 8'd5, 8'h00, 36'h0, 8'h01, 1, 1});
    vecs.push_back('{0, 0, 1, 8'h00, 8'h00, 36'h0, 8'hFF, 0, 1});
    vecs.push_back('{0, 1, 0, BASE + 8'd0, 8'h00, 36'h0, 8'hFF, 0, 0});
    vecs.push_back('{0, 0, 0, BASE + 8'd0, 8'h00, 36'h0, 8'h20, 0, 0});
    vecs.push_back('{0, 0, 0, BASE + 8'd7, 8'h00, 36'h0, 8'h01, 0, 0});
    vecs.push_back('{0, 0, 0, 8'h00, 8'h00, 36'h0, 8'hFF, 0, 0});

    foreach (vecs[i]) begin
      if (vecs[i].valid) begin
        {smp_status, smp_x, smp_y, smp_dx, smp_dy} = vecs[i].smp;
        sample_valid = 1;
      end
      bus_addr = vecs[i].addr; bus_we = vecs[i].we; tb_drv_en = vecs[i].we;
      tb_drv_data = vecs[i].wdata; ack = vecs[i].ack;
      step();
      chk($sformatf("vec%0d bus", i), 32'(last_bus), 32'(vecs[i].exp_bus));
      chk($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      chk($sformatf("vec%0d count", i), 32'(fifo_count), 32'(vecs[i].exp_cnt));
    end

    // Overflow on the ninth push; drain preserves order; CTRL bit1 clears.
    for (int i = 1; i <= 9; i++) push(4'h0, 8'(i));
    chk("ovf count", 32'(fifo_count), 32'd8);
    chk("ovf flag", 32'(overflow), 32'd1);
    rd(3'd0, v8);
    chk("ovf status", 32'(v8), 32'hC0);
    for (int i = 1; i <= 8; i++) begin
      rd(3'd1, v8);
      chk($sformatf("drain x%0d", i), 32'(v8), 32'(i));
      wr(3'd0, 8'h00);
    end
    chk("drained count", 32'(fifo_count), 32'd0);
    wr(3'd6, 8'h03);
    chk("ovf cleared", 32'(overflow), 32'd0);
    ack = 1;
    step();
    chk("ack clears irq", 32'(irq), 32'd0);

    // Threshold of 3; set beats a same-cycle ack.
    wr(3'd7, 8'h03);
    push(4'h1, 8'h31);
    push(4'h1, 8'h32);
    chk("below thresh irq", 32'(irq), 32'd0);
    push(4'h1, 8'h33);
    chk("at thresh irq", 32'(irq), 32'd1);
    ack = 1;
    push(4'h1, 8'h34);
    chk("set beats ack", 32'(irq), 32'd1);
    for (int i = 0; i < 4; i++) wr(3'd0, 8'h00);
    ack = 1;
    step();

    // Full FIFO push+pop, then empty FIFO push+pop.
    for (int i = 1; i <= 8; i++) push(4'h2, 8'h40 + 8'(i));
    chk("fill count", 32'(fifo_count), 32'd8);
    set_sample(4'h2, 8'h55);
    wr(3'd0, 8'h00);
    chk("full pushpop count", 32'(fifo_count), 32'd8);
    chk("full pushpop ovf", 32'(overflow), 32'd0);
    rd(3'd1, v8);
    chk("head advanced", 32'(v8), 32'h42);
    for (int i = 0; i < 8; i++) wr(3'd0, 8'h00);
    chk("empty again", 32'(fifo_count), 32'd0);
    set_sample(4'h3, 8'h66);
    wr(3'd0, 8'h00);
    chk("empty pushpop count", 32'(fifo_count), 32'd1);
    rd(3'd1, v8);
    chk("empty pushpop x", 32'(v8), 32'h66);
    wr(3'd0, 8'h00);
    ack = 1;
    step();

    // Reset mid-burst, with a read and a push in the reset cycle.
    for (int i = 0; i < 5; i++) push(4'h4, 8'h70 + 8'(i));
    chk("burst count", 32'(fifo_count), 32'd5);
    chk("burst irq", 32'(irq), 32'd1);
    set_sample(4'h4, 8'h7F);
    bus_addr = BASE;
    rst = 1;
    step();
    chk("rst count", 32'(fifo_count), 32'd0);
    chk("rst irq", 32'(irq), 32'd0);
    chk("rst ovf", 32'(overflow), 32'd0);
    chk("rst bus z", 32'(last_bus), 32'hFF);
    wr(3'd6, 8'h00);
    push(4'h5, 8'h80);
    chk("masked irq", 32'(irq), 32'd0);
    chk("masked count", 32'(fifo_count), 32'd1);
    rst = 1;
    step();

    // Randomized traffic against the model.
    begin
      bit prev_read = 0;
      int op;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 199) == 0) rst = 1;
        if ($urandom_range(0, 99) < 45) begin
          smp_status = 4'($urandom); smp_x = 8'($urandom); smp_y = 8'($urandom);
          smp_dx = 8'($urandom); smp_dy = 8'($urandom);
          sample_valid = 1;
        end
        ack = ($urandom_range(0, 4) == 0);
        op = $urandom_range(0, 9);
        prev_read = prev_read && !rst;
        if (op <= 3) begin
          bus_addr = BASE + 8'($urandom_range(0, 7));
          bus_we = 0;
        end else if (op <= 5 && !prev_read) begin
          bus_addr = BASE + (($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(0, 7)));
          bus_we = 1; tb_drv_en = 1;
          if (bus_addr == BASE + 8'd7) tb_drv_data = 8'($urandom_range(0, 4));
          else if (bus_addr == BASE + 8'd6)
            tb_drv_data = {6'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0)};
          else tb_drv_data = 8'($urandom);
        end else if (op == 6) begin
          case ($urandom_range(0, 3))
            0: bus_addr = 8'h9F;
            1: bus_addr = 8'hA8;
            2: bus_addr = 8'h00;
            default: bus_addr = 8'hFF;
          endcase
          bus_we = !prev_read && ($urandom_range(0, 1) == 1);
          tb_drv_en = bus_we; tb_drv_data = 8'h00;
        end
        prev_read = !bus_we && (bus_addr >= BASE) && (bus_addr <= BASE + 8'd7);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
